// File: rtl/pic_priority_arbiter.sv
// rtl/pic_priority_arbiter.sv - 8259 PIC request/in-service arbiter with fixed or rotating priority
//
// Holds IRR and ISR. Picks the highest-priority unmasked request in the rotated
// order base+1 .. base (mod 8). Raises a registered interrupt when that request
// outranks everything in service. Commits the winner to ISR on latch_in_service.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   init_clear               ICW1 pulse, synchronous re-initialisation
//   level_edge_triggered     1 = level-sensitive IRR, 0 = rising-edge IRR
//   irq_request, int_mask    raw IR lines and the request mask
//   latch_in_service         commit the current winner to ISR
//   end_of_ack_seq           end of acknowledge; drives automatic EOI
//   auto_eoi_config          automatic EOI enable
//   rotate_on_aeoi           rotate on automatic EOI
//   eoi, rotate_on_eoi       ISR bits to clear, optionally rotating
//   set_priority             load priority_level as the lowest priority
//   interrupt                registered request towards the CPU side
//   irr, isr                 request and in-service registers
//   highest_level_in_service one-hot top-priority ISR bit
//   acknowledge_interrupt    one-hot level taken by the last latch (0 = spurious)
//   interrupt_id             binary index of that level, 7 on spurious

module pic_priority_arbiter #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               init_clear,
   input  logic               level_edge_triggered,
   input  logic [NUM_IRQ-1:0] irq_request,
   input  logic [NUM_IRQ-1:0] int_mask,
   input  logic               latch_in_service,
   input  logic               end_of_ack_seq,
   input  logic               auto_eoi_config,
   input  logic               rotate_on_aeoi,
   input  logic [NUM_IRQ-1:0] eoi,
   input  logic               rotate_on_eoi,
   input  logic               set_priority,
   input  logic [2:0]         priority_level,
   output logic               interrupt,
   output logic [NUM_IRQ-1:0] irr,
   output logic [NUM_IRQ-1:0] isr,
   output logic [NUM_IRQ-1:0] highest_level_in_service,
   output logic [NUM_IRQ-1:0] acknowledge_interrupt,
   output logic [2:0]         interrupt_id
);

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // Walks the rotated order starting just above the lowest-priority level.
   function automatic pick_t pick_highest(input logic [NUM_IRQ-1:0] v,
                                          input logic [2:0] lowest);
      pick_t      p;
      logic [2:0] pos;
      p.found = 1'b0;
      p.idx   = 3'd7;
      for (int k = 0; k < NUM_IRQ; k++) begin
         pos = lowest + 3'(k) + 3'd1;
         if (!p.found && v[pos]) begin
            p.found = 1'b1;
            p.idx   = pos;
         end
      end
      return p;
   endfunction

   function automatic logic [2:0] lowest_set(input logic [NUM_IRQ-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   logic [NUM_IRQ-1:0] irq_prev;
   logic [2:0]         base;

   logic [NUM_IRQ-1:0] candidate;
   pick_t              win;
   pick_t              svc;
   logic [2:0]         win_rank;
   logic [2:0]         svc_rank;
   logic               interrupt_next;
   logic [NUM_IRQ-1:0] latched;
   logic [NUM_IRQ-1:0] aeoi_clear;
   logic [NUM_IRQ-1:0] isr_next;
   logic [NUM_IRQ-1:0] irr_next;
   logic [2:0]         base_next;

   always_comb begin
      candidate = irr & ~int_mask;
      win       = pick_highest(candidate, base);
      svc       = pick_highest(isr, base);

      // Rank 0 is the highest priority in the current rotation.
      win_rank  = win.idx - base - 3'd1;
      svc_rank  = svc.idx - base - 3'd1;

      // Fully nested: only a strictly higher rank than the top in-service level interrupts.
      interrupt_next = win.found && (!svc.found || (win_rank < svc_rank));

      latched    = (latch_in_service && win.found) ? (NUM_IRQ'(1) << win.idx) : '0;
      aeoi_clear = (end_of_ack_seq && auto_eoi_config) ? acknowledge_interrupt : '0;

      // The latched bit is OR-ed last so a same-cycle EOI cannot cancel it.
      isr_next = (isr & ~eoi & ~aeoi_clear) | latched;

      // In edge mode a fresh rising edge re-arms the bit even while it is being latched.
      if (level_edge_triggered) begin
         irr_next = irq_request;
      end else begin
         irr_next = (irq_request & ~irq_prev) | (irr & irq_request & ~latched);
      end

      // Precedence: EOI rotation, then automatic-EOI rotation, then set_priority.
      base_next = base;
      if (rotate_on_eoi && (|eoi)) base_next = lowest_set(eoi);
      if (rotate_on_aeoi && (|aeoi_clear)) base_next = lowest_set(aeoi_clear);
      if (set_priority) base_next = priority_level;

      highest_level_in_service = svc.found ? (NUM_IRQ'(1) << svc.idx) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irr                   <= '0;
         isr                   <= '0;
         irq_prev              <= '0;
         acknowledge_interrupt <= '0;
         interrupt             <= 1'b0;
         interrupt_id          <= 3'd7;
         base                  <= 3'd7;
      end else if (init_clear) begin
         irr                   <= '0;
         isr                   <= '0;
         irq_prev              <= '0;
         acknowledge_interrupt <= '0;
         interrupt             <= 1'b0;
         interrupt_id          <= 3'd7;
         base                  <= 3'd7;
      end else begin
         irr       <= irr_next;
         isr       <= isr_next;
         irq_prev  <= irq_request;
         interrupt <= interrupt_next;
         base      <= base_next;
         if (latch_in_service) begin
            acknowledge_interrupt <= latched;
            interrupt_id          <= win.found ? win.idx : 3'd7;
         end
      end
   end

endmodule

// File: tb/tb_pic_priority_arbiter.sv
// tb/tb_pic_priority_arbiter.sv - self-checking bench for pic_priority_arbiter

module tb_pic_priority_arbiter;

   logic       clk;
   logic       reset_n;
   logic       init_clear;
   logic       level_edge_triggered;
   logic [7:0] irq_request;
   logic [7:0] int_mask;
   logic       latch_in_service;
   logic       end_of_ack_seq;
   logic       auto_eoi_config;
   logic       rotate_on_aeoi;
   logic [7:0] eoi;
   logic       rotate_on_eoi;
   logic       set_priority;
   logic [2:0] priority_level;
   logic       interrupt;
   logic [7:0] irr;
   logic [7:0] isr;
   logic [7:0] highest_level_in_service;
   logic [7:0] acknowledge_interrupt;
   logic [2:0] interrupt_id;

   int vectors;
   int miscompares;

   pic_priority_arbiter #(.NUM_IRQ(8)) dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .init_clear               (init_clear),
      .level_edge_triggered     (level_edge_triggered),
      .irq_request              (irq_request),
      .int_mask                 (int_mask),
      .latch_in_service         (latch_in_service),
      .end_of_ack_seq           (end_of_ack_seq),
      .auto_eoi_config          (auto_eoi_config),
      .rotate_on_aeoi           (rotate_on_aeoi),
      .eoi                      (eoi),
      .rotate_on_eoi            (rotate_on_eoi),
      .set_priority             (set_priority),
      .priority_level           (priority_level),
      .interrupt                (interrupt),
      .irr                      (irr),
      .isr                      (isr),
      .highest_level_in_service (highest_level_in_service),
      .acknowledge_interrupt    (acknowledge_interrupt),
      .interrupt_id             (interrupt_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: priority by rank arithmetic, IRR rules bit by bit.
   logic [7:0] m_irr, m_isr, m_ack, m_prev;
   logic [2:0] m_id;
   logic       m_int;
   int         m_base;

   function automatic int m_rank(int i);
      return (i - m_base + 7) % 8;
   endfunction

   function automatic int m_best(logic [7:0] v);
      int best;
      best = -1;
      for (int i = 0; i < 8; i++)
         if (v[i] && (best < 0 || m_rank(i) < m_rank(best))) best = i;
      return best;
   endfunction

   function automatic logic [7:0] m_hlis();
      int b;
      logic [7:0] r;
      b = m_best(m_isr);
      r = 8'h00;
      if (b >= 0) r[b] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_irr = 8'h00; m_isr = 8'h00; m_ack = 8'h00; m_prev = 8'h00;
      m_id = 3'd7; m_int = 1'b0; m_base = 7;
   endtask

   task automatic tick();
      logic [7:0] n_irr, n_isr, n_ack, aeoi_clr, lat;
      logic [2:0] n_id;
      logic       n_int;
      int         n_base, w, s;
      w = m_best(m_irr & ~int_mask);
      s = m_best(m_isr);
      n_int = (w >= 0) && (m_isr == 8'h00 || m_rank(w) < m_rank(s));
      lat = 8'h00;
      if (latch_in_service && w >= 0) lat[w] = 1'b1;
      aeoi_clr = (end_of_ack_seq && auto_eoi_config) ? m_ack : 8'h00;
      n_isr = (m_isr & ~eoi & ~aeoi_clr) | lat;
      for (int i = 0; i < 8; i++) begin
         if (level_edge_triggered)               n_irr[i] = irq_request[i];
         else if (irq_request[i] && !m_prev[i])  n_irr[i] = 1'b1;
         else if (!irq_request[i])               n_irr[i] = 1'b0;
         else if (lat[i])                        n_irr[i] = 1'b0;
         else                                    n_irr[i] = m_irr[i];
      end
      n_base = m_base;
      if (rotate_on_eoi && eoi != 8'h00)
         for (int i = 7; i >= 0; i--) if (eoi[i]) n_base = i;
      if (rotate_on_aeoi && aeoi_clr != 8'h00)
         for (int i = 0; i < 8; i++) if (aeoi_clr[i]) n_base = i;
      if (set_priority) n_base = int'(priority_level);
      n_ack = m_ack;
      n_id  = m_id;
      if (latch_in_service) begin
         n_ack = lat;
         n_id  = (w >= 0) ? 3'(w) : 3'd7;
      end
      @(posedge clk);
      #1;
      if (init_clear) begin
         model_reset();
      end else begin
         m_irr = n_irr; m_isr = n_isr; m_ack = n_ack; m_id = n_id;
         m_int = n_int; m_base = n_base; m_prev = irq_request;
      end
      init_clear = 1'b0; latch_in_service = 1'b0; end_of_ack_seq = 1'b0;
      eoi = 8'h00; set_priority = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      init_clear = 0; level_edge_triggered = 0; irq_request = 0; int_mask = 0;
      latch_in_service = 0; end_of_ack_seq = 0; auto_eoi_config = 0;
      rotate_on_aeoi = 0; eoi = 0; rotate_on_eoi = 0; set_priority = 0;
      priority_level = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      vectors++;
      if ({irr, isr, acknowledge_interrupt} !== 24'h0) begin
         miscompares++;
         $display("FAIL reset_regs irr/isr/ack=%h/%h/%h expected 0/0/0", irr, isr, acknowledge_interrupt);
      end
      vectors++;
      if (interrupt !== 1'b0 || interrupt_id !== 3'd7 || highest_level_in_service !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_out int=%b id=%0d hlis=%h expected 0/7/00", interrupt, interrupt_id, highest_level_in_service);
      end
   endtask

   task automatic test_nested_edge();
      level_edge_triggered = 1'b0;
      int_mask = 8'h00;
      irq_request = 8'h28;
      tick();
      tick();
      vectors++;
      if (interrupt !== 1'b1) begin
         miscompares++; $display("FAIL edge_int got %b expected 1", interrupt);
      end
      latch_in_service = 1'b1;
      tick();
      vectors++;
      if (isr !== 8'h08 || interrupt_id !== 3'd3 || irr !== 8'h20) begin
         miscompares++;
         $display("FAIL edge_latch isr=%h id=%0d irr=%h expected 08/3/20", isr, interrupt_id, irr);
      end
      tick();
      vectors++;
      if (interrupt !== 1'b0) begin
         miscompares++; $display("FAIL nested_block got %b expected 0", interrupt);
      end
   endtask

   task automatic test_eoi();
      eoi = 8'h08;
      tick();
      vectors++;
      if (isr !== 8'h00) begin
         miscompares++; $display("FAIL eoi_clear isr=%h expected 00", isr);
      end
      tick();
      vectors++;
      if (interrupt !== 1'b1) begin
         miscompares++; $display("FAIL eoi_reint got %b expected 1", interrupt);
      end
      latch_in_service = 1'b1;
      tick();
      vectors++;
      if (isr !== 8'h20 || interrupt_id !== 3'd5) begin
         miscompares++; $display("FAIL eoi_latch5 isr=%h id=%0d expected 20/5", isr, interrupt_id);
      end
      irq_request = 8'h00;
      eoi = 8'h20;
      tick();
      tick();
   endtask

   task automatic test_mask_spurious();
      level_edge_triggered = 1'b1;
      irq_request = 8'h04;
      int_mask = 8'h04;
      repeat (3) tick();
      vectors++;
      if (interrupt !== 1'b0 || irr !== 8'h04) begin
         miscompares++; $display("FAIL masked int=%b irr=%h expected 0/04", interrupt, irr);
      end
      int_mask = 8'h00;
      tick();
      tick();
      vectors++;
      if (interrupt !== 1'b1) begin
         miscompares++; $display("FAIL unmasked got %b expected 1", interrupt);
      end
      irq_request = 8'h00;
      tick();
      latch_in_service = 1'b1;
      tick();
      vectors++;
      if (acknowledge_interrupt !== 8'h00 || interrupt_id !== 3'd7 || isr !== 8'h00) begin
         miscompares++;
         $display("FAIL spurious ack=%h id=%0d isr=%h expected 00/7/00", acknowledge_interrupt, interrupt_id, isr);
      end
   endtask

   task automatic test_set_priority();
      set_priority = 1'b1;
      priority_level = 3'd4;
      irq_request = 8'h41;
      tick();
      latch_in_service = 1'b1;
      tick();
      vectors++;
      if (interrupt_id !== 3'd6 || isr !== 8'h40) begin
         miscompares++; $display("FAIL set_priority id=%0d isr=%h expected 6/40", interrupt_id, isr);
      end
      irq_request = 8'h00;
      eoi = 8'h40;
      set_priority = 1'b1;
      priority_level = 3'd7;
      tick();
   endtask

   task automatic test_aeoi_rotate();
      auto_eoi_config = 1'b1;
      rotate_on_aeoi = 1'b1;
      irq_request = 8'h02;
      tick();
      latch_in_service = 1'b1;
      tick();
      vectors++;
      if (isr !== 8'h02 || acknowledge_interrupt !== 8'h02) begin
         miscompares++; $display("FAIL aeoi_latch isr=%h ack=%h expected 02/02", isr, acknowledge_interrupt);
      end
      irq_request = 8'h00;
      end_of_ack_seq = 1'b1;
      tick();
      vectors++;
      if (isr !== 8'h00) begin
         miscompares++; $display("FAIL aeoi_clear isr=%h expected 00", isr);
      end
      irq_request = 8'h06;
      tick();
      latch_in_service = 1'b1;
      tick();
      vectors++;
      if (interrupt_id !== 3'd2) begin
         miscompares++; $display("FAIL aeoi_rotated id=%0d expected 2", interrupt_id);
      end
      irq_request = 8'h00;
      end_of_ack_seq = 1'b1;
      tick();
      auto_eoi_config = 1'b0;
      rotate_on_aeoi = 1'b0;
      set_priority = 1'b1;
      priority_level = 3'd7;
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         level_edge_triggered = ($urandom_range(0, 7) == 0) ? ~level_edge_triggered : level_edge_triggered;
         irq_request      = 8'($urandom);
         int_mask         = 8'($urandom) & 8'($urandom);
         latch_in_service = ($urandom_range(0, 3) == 0);
         end_of_ack_seq   = ($urandom_range(0, 3) == 0);
         auto_eoi_config  = ($urandom_range(0, 1) == 0);
         rotate_on_aeoi   = ($urandom_range(0, 1) == 0);
         rotate_on_eoi    = ($urandom_range(0, 1) == 0);
         eoi              = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
         set_priority     = ($urandom_range(0, 15) == 0);
         priority_level   = 3'($urandom);
         init_clear       = ($urandom_range(0, 63) == 0);
         tick();
         vectors++;
         if ({interrupt, irr, isr, highest_level_in_service, acknowledge_interrupt, interrupt_id} !==
             {m_int, m_irr, m_isr, m_hlis(), m_ack, m_id}) begin
            miscompares++;
            $display("FAIL random[%0d] int/irr/isr/hlis/ack/id=%b/%h/%h/%h/%h/%0d expected %b/%h/%h/%h/%h/%0d",
                     n, interrupt, irr, isr, highest_level_in_service, acknowledge_interrupt, interrupt_id,
                     m_int, m_irr, m_isr, m_hlis(), m_ack, m_id);
         end
      end
      init_clear = 1'b1;
      irq_request = 8'h00; int_mask = 8'h00; auto_eoi_config = 1'b0;
      rotate_on_aeoi = 1'b0; rotate_on_eoi = 1'b0;
      tick();
      vectors++;
      if ({interrupt, irr, isr, acknowledge_interrupt, interrupt_id} !== {1'b0, 24'h0, 3'd7}) begin
         miscompares++;
         $display("FAIL init_clear int/irr/isr/ack/id=%b/%h/%h/%h/%0d expected 0/00/00/00/7",
                  interrupt, irr, isr, acknowledge_interrupt, interrupt_id);
      end
   endtask

   task automatic test_latch_eoi_collision_reset();
      level_edge_triggered = 1'b1;
      irq_request = 8'h08;
      tick();
      latch_in_service = 1'b1;
      eoi = 8'h08;
      tick();
      vectors++;
      if (isr[3] !== 1'b1 || interrupt !== 1'b1) begin
         miscompares++; $display("FAIL latch_eoi isr=%h int=%b expected bit3 set, int 1", isr, interrupt);
      end
      reset_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (isr !== 8'h00 || interrupt !== 1'b0 || irr !== 8'h00 || interrupt_id !== 3'd7) begin
         miscompares++;
         $display("FAIL async_reset isr=%h int=%b irr=%h id=%0d expected 00/0/00/7", isr, interrupt, irr, interrupt_id);
      end
      #2;
      reset_n = 1'b1;
      irq_request = 8'h00;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_nested_edge();
      test_eoi();
      test_mask_spurious();
      test_set_priority();
      test_aeoi_rotate();
      test_random();
      test_latch_eoi_collision_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pic_priority_arbiter.md
Name: pic_priority_arbiter

Overview:
- Clocked interrupt request/in-service arbiter for the 8259 PIC.
- Holds IRR and ISR and resolves the highest-priority unmasked request under fixed or rotating priority.
- Raises `interrupt` to the control block, and latches the winner into ISR on `latch_in_service`.
- Consumes the mask, EOI and configuration signals produced by the control block.

Parameters:
- NUM_IRQ, 8, number of interrupt lines. Fixed at 8; level indices are 3 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- init_clear  input  1  one-cycle pulse on ICW1 write; re-initialises arbiter state
- level_edge_triggered  input  1  1 = level-sensitive IRR, 0 = rising-edge IRR
- irq_request  input  8  raw IR0..IR7 lines, synchronous to clk
- int_mask  input  8  1 = request masked
- latch_in_service  input  1  one-cycle pulse: commit current winner to ISR
- end_of_ack_seq  input  1  one-cycle pulse at end of acknowledge sequence
- auto_eoi_config  input  1  AEOI mode
- rotate_on_aeoi  input  1  rotate priority on automatic EOI
- eoi  input  8  one-hot/zero bits to clear from ISR this cycle
- rotate_on_eoi  input  1  qualifies `eoi`: rotate so the cleared level becomes lowest
- set_priority  input  1  one-cycle pulse: load `priority_level` as lowest priority
- priority_level  input  3  level for `set_priority`
- interrupt  output  1  registered interrupt request to CPU-side logic
- irr  output  8  interrupt request register
- isr  output  8  in-service register
- highest_level_in_service  output  8  one-hot highest-priority ISR bit (0 if ISR empty)
- acknowledge_interrupt  output  8  one-hot level latched by the last `latch_in_service` (0 = spurious)
- interrupt_id  output  3  binary index of `acknowledge_interrupt`; 7 on spurious

Behaviour:

Reset (reset_n=0, async)
- irr, isr, acknowledge_interrupt, irq_prev = 0
- interrupt = 0, interrupt_id = 7
- lowest-priority register `base` = 7, so IR0 is highest.
- `init_clear` applies the same values synchronously.

IRR
- Level mode: irr[i] follows the registered irq_request[i].
- Edge mode: irr[i] sets on 0→1 of irq_request[i] (compared with irq_prev), and clears when irq_request[i] is 0 or when bit i is latched.
- A new edge on the same bit in the latch cycle takes precedence: the bit stays set.

Priority resolution (combinational from registered state)
- Priority order is base+1, base+2, …, base (mod 8).
- candidate = irr & ~int_mask; winner = highest-priority candidate bit.
- highest_level_in_service = highest-priority isr bit in the same rotated order.
- interrupt (registered, 1-cycle latency) = 1 iff a winner exists AND (isr == 0 OR winner's rotated rank is strictly higher than highest_level_in_service's rank).
- Equal or lower rank never interrupts (fully nested).

Latch
- On latch_in_service:
  - isr |= winner
  - irr bit of winner cleared (subject to the edge rule above)
  - acknowledge_interrupt = winner
  - interrupt_id = index of winner
- If there is no winner: isr unchanged, acknowledge_interrupt = 0, interrupt_id = 7.
- interrupt drops on the following cycle as a result of the ISR update.

EOI
- isr_next = (isr & ~eoi & ~aeoi_clear) | latched_bit.
- A latch to a bit in the same cycle as EOI to that bit leaves the bit set.
- aeoi_clear = acknowledge_interrupt when end_of_ack_seq && auto_eoi_config, else 0.

Rotation
- If eoi is nonzero and rotate_on_eoi is set: base = index of the lowest-numbered set eoi bit.
- If aeoi_clear is nonzero and rotate_on_aeoi is set: base = index of aeoi_clear.
- On set_priority: base = priority_level.
- If both occur in the same cycle, set_priority wins.
- Rotation takes effect from the next cycle's resolution.

Other rules
- Masking never clears ISR or IRR; it only removes the bit from candidate.
- Reset mid-acknowledge drops all state immediately; no pending latch survives.

Test Plan:
1. Reset, then edge mode, mask 0x00, pulse IR3 and IR5 together → interrupt=1 after 1 cycle; latch → isr=0x08, interrupt_id=3, irr=0x20; interrupt=0 (IR5 lower than IR3 in service).
2. Continue from 1: eoi=0x08 → isr=0x00, interrupt=1 next cycle; latch → isr=0x20, interrupt_id=5.
3. Level mode, IR2 held high, int_mask=0x04 → interrupt stays 0; unmask → interrupt=1; drop IR2 before latch, then latch → acknowledge_interrupt=0x00, interrupt_id=7.
4. set_priority level=4, then IR0 and IR6 requested → winner IR6 (order 5,6,7,0…), interrupt_id=6.
5. AEOI with rotate_on_aeoi: latch IR1, then end_of_ack_seq → isr=0x00, base=1; IR1 and IR2 requested → IR2 wins.
6. Latch IR3 in the same cycle as eoi=0x08 → isr bit 3 remains 1; async reset_n low mid-sequence → isr=0, interrupt=0 immediately.
